// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cpu_ctrl_pkg : shared encodings for the multicycle CPU controller
// Rev 1.0
// ------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] C_OP_ADD  = 4'h0;
  localparam logic [3:0] C_OP_SUB  = 4'h1;
  localparam logic [3:0] C_OP_AND  = 4'h2;
  localparam logic [3:0] C_OP_OR   = 4'h3;
  localparam logic [3:0] C_OP_ADDI = 4'h4;
  localparam logic [3:0] C_OP_LW   = 4'h5;
  localparam logic [3:0] C_OP_SW   = 4'h6;
  localparam logic [3:0] C_OP_BEQ  = 4'h7;
  localparam logic [3:0] C_OP_JMP  = 4'h8;
  localparam logic [3:0] C_OP_HLT  = 4'hF;

  localparam logic [2:0] C_ALU_ADD = 3'b000;
  localparam logic [2:0] C_ALU_SUB = 3'b001;
  localparam logic [2:0] C_ALU_AND = 3'b010;
  localparam logic [2:0] C_ALU_OR  = 3'b011;

  localparam logic [1:0] C_PC_SEQ    = 2'b00;
  localparam logic [1:0] C_PC_BRANCH = 2'b01;
  localparam logic [1:0] C_PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    OPC_ALU, OPC_ALUI, OPC_LW, OPC_SW, OPC_BEQ, OPC_JMP, OPC_HLT, OPC_NOP
  } op_class_e;

  // Opcodes arrive zero-extended so any OPW works; unknown values are NOPs.
  function automatic op_class_e op_class(input logic [31:0] op);
    op_class_e c;
    case (op)
      {28'd0, C_OP_ADD}, {28'd0, C_OP_SUB},
      {28'd0, C_OP_AND}, {28'd0, C_OP_OR}:  c = OPC_ALU;
      {28'd0, C_OP_ADDI}:                    c = OPC_ALUI;
      {28'd0, C_OP_LW}:                      c = OPC_LW;
      {28'd0, C_OP_SW}:                      c = OPC_SW;
      {28'd0, C_OP_BEQ}:                     c = OPC_BEQ;
      {28'd0, C_OP_JMP}:                     c = OPC_JMP;
      {28'd0, C_OP_HLT}:                     c = OPC_HLT;
      default:                               c = OPC_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] alu_code(input logic [31:0] op);
    logic [2:0] a;
    case (op)
      {28'd0, C_OP_SUB}: a = C_ALU_SUB;
      {28'd0, C_OP_AND}: a = C_ALU_AND;
      {28'd0, C_OP_OR}:  a = C_ALU_OR;
      default:           a = C_ALU_ADD;
    endcase
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_out_decode.sv
`default_nettype none
// ------------------------------------------------------------------
// ctrl_out_decode : combinational control-signal decode per FSM state
// Rev 1.0
// ------------------------------------------------------------------
module ctrl_out_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           i_rst_act,
  input  logic [2:0]     i_state,
  input  logic [OPW-1:0] i_opcode,
  input  logic           i_zero,
  input  logic           i_mem_ready,
  output logic           o_pc_en,
  output logic           o_ir_en,
  output logic           o_ab_en,
  output logic           o_aluout_en,
  output logic           o_mdr_en,
  output logic           o_mem_rd,
  output logic           o_mem_wr,
  output logic           o_rf_we,
  output logic           o_wb_sel,
  output logic           o_alu_srcb,
  output logic [1:0]     o_pc_src,
  output logic [2:0]     o_alu_op,
  output logic           o_instr_done,
  output logic           o_halted
);

  op_class_e w_cls;

  always_comb begin
    w_cls        = op_class(32'(i_opcode));
    o_pc_en      = 1'b0;
    o_ir_en      = 1'b0;
    o_ab_en      = 1'b0;
    o_aluout_en  = 1'b0;
    o_mdr_en     = 1'b0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_rf_we      = 1'b0;
    o_wb_sel     = 1'b0;
    o_alu_srcb   = 1'b0;
    o_pc_src     = C_PC_SEQ;
    o_alu_op     = C_ALU_ADD;
    o_instr_done = 1'b0;
    o_halted     = 1'b0;

    // While in reset only the pending fetch read is advertised.
    if (i_rst_act) begin
      o_mem_rd = 1'b1;
    end else begin
      case (i_state)
        S_FETCH: begin
          o_mem_rd = 1'b1;
          o_ir_en  = i_mem_ready;
          o_pc_en  = i_mem_ready;
        end
        S_DECODE: begin
          o_ab_en = 1'b1;
          if (w_cls == OPC_JMP) begin
            o_pc_en      = 1'b1;
            o_pc_src     = C_PC_JUMP;
            o_instr_done = 1'b1;
          end else if (w_cls == OPC_NOP) begin
            o_instr_done = 1'b1;
          end
        end
        S_EXEC: begin
          case (w_cls)
            OPC_ALU: begin
              o_aluout_en = 1'b1;
              o_alu_op    = alu_code(32'(i_opcode));
            end
            OPC_ALUI, OPC_LW, OPC_SW: begin
              o_aluout_en = 1'b1;
              o_alu_srcb  = 1'b1;
            end
            OPC_BEQ: begin
              o_alu_op     = C_ALU_SUB;
              o_pc_src     = C_PC_BRANCH;
              o_pc_en      = i_zero;
              o_instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (w_cls == OPC_LW) begin
            o_mem_rd = 1'b1;
            o_mdr_en = i_mem_ready;
          end else if (w_cls == OPC_SW) begin
            o_mem_wr     = 1'b1;
            o_instr_done = i_mem_ready;
          end
        end
        S_WB: begin
          o_rf_we      = 1'b1;
          o_wb_sel     = (w_cls == OPC_LW);
          o_instr_done = 1'b1;
        end
        S_HALT: o_halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// multicycle_ctrl : FSM controller for a multicycle CPU datapath
// Rev 1.0
// ------------------------------------------------------------------
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            ir_en,
  output logic            ab_en,
  output logic            aluout_en,
  output logic            mdr_en,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            alu_srcb,
  output logic [1:0]      pc_src,
  output logic [2:0]      alu_op,
  output logic [2:0]      state,
  output logic            instr_done,
  output logic            halted,
  output logic [CNTW-1:0] instr_count
);

  state_e          state_q, state_d;
  logic [CNTW-1:0] count_q, count_d;
  op_class_e       w_cls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    w_cls   = op_class(32'(opcode));
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (w_cls == OPC_HLT)                             state_d = S_HALT;
        else if (w_cls == OPC_JMP || w_cls == OPC_NOP)    state_d = S_FETCH;
        else                                              state_d = S_EXEC;
      end
      S_EXEC: begin
        if (w_cls == OPC_ALU || w_cls == OPC_ALUI)        state_d = S_WB;
        else if (w_cls == OPC_LW || w_cls == OPC_SW)      state_d = S_MEM;
        else                                              state_d = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready) state_d = (w_cls == OPC_LW) ? S_WB : S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    count_d = count_q + {{(CNTW-1){1'b0}}, instr_done};
  end

  assign state       = state_q;
  assign instr_count = count_q;

  ctrl_out_decode #(.OPW(OPW)) u_dec (
    .i_rst_act    (!rst),
    .i_state      (state_q),
    .i_opcode     (opcode),
    .i_zero       (zero),
    .i_mem_ready  (mem_ready),
    .o_pc_en      (pc_en),
    .o_ir_en      (ir_en),
    .o_ab_en      (ab_en),
    .o_aluout_en  (aluout_en),
    .o_mdr_en     (mdr_en),
    .o_mem_rd     (mem_rd),
    .o_mem_wr     (mem_wr),
    .o_rf_we      (rf_we),
    .o_wb_sel     (wb_sel),
    .o_alu_srcb   (alu_srcb),
    .o_pc_src     (pc_src),
    .o_alu_op     (alu_op),
    .o_instr_done (instr_done),
    .o_halted     (halted)
  );

endmodule
`default_nettype wire
